// File: rtl/sum_tx_sequencer.sv
// sum_tx_sequencer: latches two 4-bit operands on async save strobes and sends {A,B}, sum as a UART frame.
// Define SUMSEQ_CHECKSUM_EN to append a checksum byte (3-byte frame); default build sends 2 bytes.
module sum_tx_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       save_a_n,
  input  logic       save_b_n,
  input  logic [3:0] data_input,
  input  logic       send_req,
  input  logic       uart_tx_busy,
  output logic       uart_tx_en,
  output logic [7:0] uart_tx_data,
  output logic       seq_busy,
  output logic       frame_done,
  output logic [4:0] sum_out
);

`ifdef SUMSEQ_CHECKSUM_EN
  localparam logic [1:0] LAST_IDX = 2'd2;
`else
  localparam logic [1:0] LAST_IDX = 2'd1;
`endif
  localparam logic [7:0] ACK_LIMIT = 8'(ACK_TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, START, WAIT_ACK, WAIT_DONE} state_t;
  state_t state;

  logic [1:0] sync_a, sync_b;
  logic       prev_a, prev_b;
  logic       fall_a, fall_b;
  logic [3:0] op_a, op_b;
  logic [3:0] snap_a, snap_b;
  logic [4:0] snap_sum;
  logic [1:0] idx;
  logic [7:0] ack_cnt;
  logic       pending;
  logic [7:0] byte_sel;

  // Strobes idle high, so the synchronizer chain resets to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '1;
      sync_b <= '1;
      prev_a <= 1'b1;
      prev_b <= 1'b1;
    end else begin
      sync_a <= {sync_a[0], save_a_n};
      sync_b <= {sync_b[0], save_b_n};
      prev_a <= sync_a[1];
      prev_b <= sync_b[1];
    end
  end

  assign fall_a = prev_a & ~sync_a[1];
  assign fall_b = prev_b & ~sync_b[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a <= '0;
      op_b <= '0;
    end else begin
      if (fall_a) op_a <= data_input;
      if (fall_b) op_b <= data_input;
    end
  end

  assign sum_out = {1'b0, op_a} + {1'b0, op_b};

  always_comb begin
    byte_sel = {snap_a, snap_b};
    case (idx)
      2'd0:    byte_sel = {snap_a, snap_b};
      2'd1:    byte_sel = {3'b000, snap_sum};
`ifdef SUMSEQ_CHECKSUM_EN
      2'd2:    byte_sel = {snap_a, snap_b} ^ {3'b000, snap_sum} ^ 8'h5A;
`endif
      default: byte_sel = {snap_a, snap_b};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      uart_tx_en   <= 1'b0;
      uart_tx_data <= '0;
      seq_busy     <= 1'b0;
      frame_done   <= 1'b0;
      pending      <= 1'b0;
      snap_a       <= '0;
      snap_b       <= '0;
      snap_sum     <= '0;
      idx          <= '0;
      ack_cnt      <= '0;
    end else begin
      uart_tx_en <= 1'b0;
      frame_done <= 1'b0;
      if (send_req && seq_busy) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (send_req || pending) begin
            snap_a   <= op_a;
            snap_b   <= op_b;
            snap_sum <= sum_out;
            idx      <= '0;
            pending  <= 1'b0;
            seq_busy <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (!uart_tx_busy) begin
            uart_tx_en   <= 1'b1;
            uart_tx_data <= byte_sel;
            ack_cnt      <= '0;
            state        <= WAIT_ACK;
          end
        end
        // The START hop costs a cycle, so timing out after ACK_TIMEOUT-1 cycles here
        // spaces the re-issued start exactly ACK_TIMEOUT cycles after the first one.
        WAIT_ACK: begin
          if (uart_tx_busy) begin
            state <= WAIT_DONE;
          end else if (ack_cnt == ACK_LIMIT) begin
            state <= START;
          end else begin
            ack_cnt <= ack_cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (!uart_tx_busy) begin
            if (idx == LAST_IDX) begin
              frame_done <= 1'b1;
              seq_busy   <= 1'b0;
              state      <= IDLE;
            end else begin
              idx   <= idx + 2'd1;
              state <= START;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sum_tx_sequencer.md
# sum_tx_sequencer

Controller between the operand latches/adder and the byte-wide UART transmitter of the SumLatchUART system. It captures two 4-bit operands on active-low save strobes and forms their 5-bit sum. On a send request it snapshots the operands and sequences a fixed multi-byte frame into the UART. It owns the start/busy handshake, queues one pending request, and recovers from a transmitter that never acknowledges a start.

## Interface
Parameters:
- ACK_TIMEOUT, 16: cycles to wait for `uart_tx_busy` to rise after `uart_tx_en` before re-issuing the start; legal range 2–255.

Ports:
- clk  input  1  system clock; all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- save_a_n  input  1  active-low strobe; falling edge latches `data_input` into operand A; asynchronous to clk
- save_b_n  input  1  as `save_a_n`, for operand B
- data_input  input  4  operand value; must be stable around save strobes
- send_req  input  1  synchronous request to transmit one frame; level-sampled each cycle
- uart_tx_busy  input  1  high while the UART is shifting a byte
- uart_tx_en  output  1  one-cycle start pulse to the UART
- uart_tx_data  output  8  byte presented to the UART; valid and held from the `uart_tx_en` cycle until `uart_tx_busy` falls
- seq_busy  output  1  high from request acceptance until frame completion
- frame_done  output  1  one-cycle pulse after the last byte completes
- sum_out  output  5  live A+B, zero-extended

## Operation
- Save strobes: 2-FF synchronizer per strobe, then falling-edge detect. On a detected edge, `data_input` is latched into A or B in that same cycle. Simultaneous A and B edges latch the same value into both.
- sum_out = {1'b0,A} + {1'b0,B}, 5 bits, no overflow possible (max 30).
- Frame, in order: byte0 = {A,B}; byte1 = {3'b000,sum}; byte2 (checksum, see Configuration) = byte0 ^ byte1 ^ 8'h5A.
- The snapshot of A, B and sum is taken when a request is accepted. Saves during a frame update A/B and sum_out but not the frame in flight.
- FSM states: IDLE, START, WAIT_ACK, WAIT_DONE.
  - IDLE: `send_req`=1, or the pending flag set → take snapshot, byte index=0, clear pending flag → START.
  - START: if `uart_tx_busy`=0, assert `uart_tx_en` for one cycle → WAIT_ACK. Otherwise hold in START with `uart_tx_en`=0.
  - WAIT_ACK: `uart_tx_busy`=1 → WAIT_DONE. If ACK_TIMEOUT cycles elapse without busy → START, which re-issues the same byte.
  - WAIT_DONE: `uart_tx_busy`=0 → if index is the last byte, pulse `frame_done` and → IDLE; else index+1 → START.
- `send_req` while `seq_busy`=1 sets a single pending flag. Further requests while the flag is set are dropped. The pending request starts from IDLE on the cycle after `frame_done`.
- Reset mid-frame aborts immediately. The UART may finish its current byte, but no further bytes are issued.

## Timing
- Reset values: A=B=0, sum_out=0, uart_tx_en=0, uart_tx_data=8'h00, seq_busy=0, frame_done=0, pending=0, state IDLE.
- Save latency: strobe falling edge to A/B updated = 3 clk edges (2 sync + edge detect).
- `send_req` high at edge N in IDLE with UART idle:
  - `seq_busy`=1 after edge N.
  - `uart_tx_en`=1 for the cycle after edge N+1, carrying byte0 on `uart_tx_data`.
- Inter-byte gap: `uart_tx_en` for the next byte is asserted 2 cycles after `uart_tx_busy` is sampled low.
- `frame_done` is high for the cycle after the edge that sees the last byte's busy fall. `seq_busy` drops on that same edge.
- `uart_tx_en` is never high in two consecutive cycles.

## Configuration
- `SUMSEQ_CHECKSUM_EN` defined: frame is 3 bytes, with byte2 checksum as defined above.
- Not defined: frame is 2 bytes (byte0, byte1). The checksum logic is absent, and `frame_done` follows byte1.

## Test plan
- Reset: hold `reset_n`=0 with random inputs → all outputs at reset values. Release → no `uart_tx_en` without a request.
- Save path: data_input=4'h9, pulse `save_a_n`; data_input=4'h7, pulse `save_b_n` → after 3 cycles each, sum_out=5'h10.
- Frame: A=9, B=7, `send_req` for one cycle, UART model with busy for 10 cycles → bytes 8'h97, 8'h10, then 8'hDD (checksum build) → one `frame_done` pulse.
- Snapshot: start frame with A=9, B=7; save A=4'h1 during byte0 → frame still sends 8'h97/8'h10 while sum_out=5'h08. Request during the frame → second frame sends 8'h17/8'h08 right after `frame_done`.
- Timeout: UART model ignores the first start → `uart_tx_en` re-issued exactly ACK_TIMEOUT cycles later with the same byte. Frame then completes normally.
- Reset mid-frame: assert `reset_n` low during WAIT_DONE of byte1 → outputs return to reset values immediately. No later bytes are issued and no `frame_done` pulse occurs.
